// File: rtl/apb4m_pkg.sv
// Shared types and width helpers for the APB4 requester.
package apb4m_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_RMW   = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    // Never narrower than one bit so a disabled timeout still elaborates cleanly.
    function automatic int tcnt_width(input int timeout_cyc);
        return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/apb4m_timeout.sv
// ACCESS-phase wait counter; flags the cycle on which a still-waiting transfer must be aborted.
module apb4m_timeout
    import apb4m_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYC > 0) begin : g_cnt
            localparam int CW = tcnt_width(TIMEOUT_CYC);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // cnt holds the number of wait cycles already spent, so this is the last allowed one.
            assign expired = (cnt == CW'(TIMEOUT_CYC - 1));
        end else begin : g_off
            logic unused_tie;
            assign unused_tie = clk ^ rst_n ^ clr ^ en;
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb4m_ctrl.sv
// APB4 requester: one transfer at a time from a command channel, result on a response channel,
// with hardware read-modify-write and an ACCESS-phase timeout.
module apb4m_ctrl
    import apb4m_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                            pclk,
    input  logic                            presetn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [ADDR_W-1:0]               cmd_addr,
    input  logic [DATA_W-1:0]               cmd_wdata,
    input  logic [strb_width(DATA_W)-1:0]   cmd_strb,
    input  logic [DATA_W-1:0]               cmd_mask,
    input  logic [2:0]                      cmd_prot,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            rsp_slverr,
    output logic                            rsp_timeout,
    output logic                            psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [ADDR_W-1:0]               paddr,
    output logic [DATA_W-1:0]               pwdata,
    output logic [strb_width(DATA_W)-1:0]   pstrb,
    output logic [2:0]                      pprot,
    input  logic [DATA_W-1:0]               prdata,
    input  logic                            pready,
    input  logic                            pslverr
);

    state_e            state, state_next;
    logic              rmw_q, wphase_q;
    logic [DATA_W-1:0] wdata_q, mask_q;
    logic              accept, acc_done, acc_abort, rmw_go, acc_end, to_expired;
    logic              cmd_is_write, cmd_is_rmw;

    function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] new_val,
                                                    input logic [DATA_W-1:0] mask,
                                                    input logic [DATA_W-1:0] old_val);
        return (new_val & mask) | (old_val & ~mask);
    endfunction

    // Opcode 3 is not decoded, so it falls through as a plain read.
    assign cmd_is_write = (cmd_op == OP_WRITE);
    assign cmd_is_rmw   = (cmd_op == OP_RMW);
    assign accept       = cmd_valid && cmd_ready;
    assign acc_end      = acc_abort || (acc_done && !rmw_go);

    apb4m_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (pclk),
        .rst_n   (presetn),
        .clr     (state == ST_SETUP),
        .en      ((state == ST_ACCESS) && !pready),
        .expired (to_expired)
    );

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        rsp_valid  = 1'b0;
        acc_done   = 1'b0;
        acc_abort  = 1'b0;
        rmw_go     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = presetn;
                if (cmd_valid) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                // A completing pready takes priority over an expiring timeout on the same edge.
                if (pready) begin
                    acc_done = 1'b1;
                    if (rmw_q && !wphase_q && !pslverr) begin
                        rmw_go     = 1'b1;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_RESP;
                    end
                end else if (to_expired) begin
                    acc_abort  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            rmw_q       <= 1'b0;
            wphase_q    <= 1'b0;
        end else begin
            if (accept) begin
                paddr    <= cmd_addr;
                pprot    <= cmd_prot;
                pwrite   <= cmd_is_write;
                pwdata   <= cmd_is_write ? cmd_wdata : '0;
                pstrb    <= cmd_is_write ? cmd_strb : '0;
                rmw_q    <= cmd_is_rmw;
                wphase_q <= 1'b0;
            end
            if (rmw_go) begin
                pwrite    <= 1'b1;
                pstrb     <= '1;
                pwdata    <= rmw_merge(wdata_q, mask_q, prdata);
                wphase_q  <= 1'b1;
                rsp_rdata <= prdata;
            end
            // The RMW write phase keeps the original read value captured above.
            if (acc_end) begin
                rsp_slverr  <= acc_abort || pslverr;
                rsp_timeout <= acc_abort;
                if (!wphase_q) begin
                    if (pwrite) begin
                        rsp_rdata <= '0;
                    end else begin
                        rsp_rdata <= acc_done ? prdata : '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (accept) begin
            wdata_q <= cmd_wdata;
            mask_q  <= cmd_mask;
        end
    end

endmodule

// File: tb/tb_apb4m_ctrl.sv
// Bench for apb4m_ctrl: scripted slave, transaction-level timeline model, per-cycle compare.
module tb_apb4m_ctrl;

    localparam int T     = 4;
    localparam int NDIR  = 8;
    localparam int NRAND = 250;
    localparam int LIMIT = 20000;

    logic        pclk = 1'b0;
    logic        presetn, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_wdata, cmd_mask, rsp_rdata, paddr, pwdata, prdata;
    logic [3:0]  cmd_strb, pstrb;
    logic [2:0]  cmd_prot, pprot;
    logic        rsp_slverr, rsp_timeout, psel, penable, pwrite, pready, pslverr;

    always #5 pclk = ~pclk;

    apb4m_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_mask(cmd_mask), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        int          op;
        logic [31:0] addr, wdata, mask, rd1, rd2;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          w1, w2;
        bit          err1, err2;
        int          rst_at;
        int          hold;
    } cmd_t;

    typedef struct {
        bit          psel, penable, pwrite;
        logic [31:0] paddr, pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
        bit          pready, pslverr;
        logic [31:0] prdata;
        bit          rst;
    } cyc_t;

    cmd_t        cmds[$];
    cyc_t        exp_q[$];
    bit          resp_pend, e_slverr, e_to, prev_rv, post_rst;
    logic [31:0] e_rdata;
    int          hold_left, n_pass, n_total, cyc, cmd_i, cur_idx, hs_cyc, acc_cnt, wr_cnt;

    int          lat_tab[NDIR]   = '{3, 6, 5, 6, 4, 4, -1, 3};
    logic [31:0] rdata_tab[NDIR] = '{32'h0, 32'h1234_5678, 32'hFFFF_0000, 32'h0,
                                     32'h0, 32'h0BAD_0BAD, 32'h0, 32'hCAFE_F00D};
    int          acc_tab[NDIR]   = '{1, 4, 2, 4, 2, 2, 0, 1};
    int          wr_tab[NDIR]    = '{2, 0, 2, 0, 3, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic add_cmd(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] mask, input logic [2:0] prot,
                           input int w1, input bit err1, input logic [31:0] rd1,
                           input int w2, input bit err2, input logic [31:0] rd2,
                           input int rst_at, input int hold);
        cmd_t c;
        c.op = op; c.addr = addr; c.wdata = wdata; c.strb = strb; c.mask = mask; c.prot = prot;
        c.w1 = w1; c.err1 = err1; c.rd1 = rd1; c.w2 = w2; c.err2 = err2; c.rd2 = rd2;
        c.rst_at = rst_at; c.hold = hold;
        cmds.push_back(c);
    endtask

    // One APB phase: a SETUP cycle then the ACCESS cycles the slave script implies.
    task automatic push_phase(input cmd_t c, input bit wr, input logic [31:0] wd, input logic [3:0] st,
                              input int w, input bit err, input logic [31:0] rd, input int rst_at,
                              output bit done);
        cyc_t r;
        int   n;
        r.psel = 1'b1; r.penable = 1'b0; r.pwrite = wr; r.paddr = c.addr; r.pwdata = wd;
        r.pstrb = st; r.pprot = c.prot; r.rst = 1'b0;
        r.pready = $urandom_range(0, 1) != 0; r.pslverr = $urandom_range(0, 1) != 0; r.prdata = $urandom;
        exp_q.push_back(r);
        done = (w + 1 <= T);
        n = done ? w + 1 : T;
        for (int k = 0; k < n; k++) begin
            r.penable = 1'b1;
            r.rst = (k == rst_at);
            if (done && k == n - 1) begin
                r.pready = 1'b1; r.pslverr = err; r.prdata = rd;
            end else begin
                r.pready = 1'b0; r.pslverr = $urandom_range(0, 1) != 0; r.prdata = $urandom;
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic build(input cmd_t c);
        bit wr, rmw, d1, d2;
        wr  = (c.op == 0);
        rmw = (c.op == 2);
        push_phase(c, wr, wr ? c.wdata : 32'h0, wr ? c.strb : 4'h0, c.w1, c.err1, c.rd1, c.rst_at, d1);
        e_to     = !d1;
        e_slverr = !d1 || c.err1;
        e_rdata  = wr ? 32'h0 : (d1 ? c.rd1 : 32'h0);
        if (rmw && d1 && !c.err1) begin
            push_phase(c, 1'b1, (c.wdata & c.mask) | (c.rd1 & ~c.mask), 4'hF, c.w2, c.err2, c.rd2, -1, d2);
            e_to     = !d2;
            e_slverr = !d2 || c.err2;
        end
        resp_pend = 1'b1;
        hold_left = c.hold;
    endtask

    task automatic check_zero();
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pstrb", 32'(pstrb), 32'h0);
        check("rst_pprot", 32'(pprot), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_slverr", 32'(rsp_slverr), 32'h0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
    endtask

    task automatic compare();
        cyc_t r;
        if (exp_q.size() > 0) begin
            r = exp_q[0];
            check("cmd_ready", 32'(cmd_ready), 32'h0);
            check("rsp_valid", 32'(rsp_valid), 32'h0);
            check("psel", 32'(psel), 32'(r.psel));
            check("penable", 32'(penable), 32'(r.penable));
            check("pwrite", 32'(pwrite), 32'(r.pwrite));
            check("paddr", paddr, r.paddr);
            check("pwdata", pwdata, r.pwdata);
            check("pstrb", 32'(pstrb), 32'(r.pstrb));
            check("pprot", 32'(pprot), 32'(r.pprot));
        end else if (resp_pend) begin
            check("cmd_ready", 32'(cmd_ready), 32'h0);
            check("rsp_valid", 32'(rsp_valid), 32'h1);
            check("psel", 32'(psel), 32'h0);
            check("penable", 32'(penable), 32'h0);
            check("rsp_rdata", rsp_rdata, e_rdata);
            check("rsp_slverr", 32'(rsp_slverr), 32'(e_slverr));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
        end else begin
            check("cmd_ready", 32'(cmd_ready), 32'(presetn));
            check("rsp_valid", 32'(rsp_valid), 32'h0);
            check("psel", 32'(psel), 32'h0);
            check("penable", 32'(penable), 32'h0);
        end

        if (psel && penable) acc_cnt++;
        if (psel && pwrite) wr_cnt++;

        if (cur_idx == 0 && psel) begin
            check("t1_paddr", paddr, 32'h0000_0010);
            check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
            check("t1_pwrite", 32'(pwrite), 32'h1);
        end
        if (cur_idx == 1 && psel) begin
            check("t2_pstrb", 32'(pstrb), 32'h0);
            check("t2_paddr", paddr, 32'h0000_0020);
        end
        if (cur_idx == 2 && psel && pwrite) begin
            check("t3_merge_pwdata", pwdata, 32'hFFFF_00AA);
            check("t3_merge_pstrb", 32'(pstrb), 32'hF);
        end
        if (rsp_valid && !prev_rv && cur_idx >= 0 && cur_idx < NDIR) begin
            check("dir_latency", 32'(cyc - hs_cyc), 32'(lat_tab[cur_idx]));
            check("dir_rdata", rsp_rdata, rdata_tab[cur_idx]);
            check("dir_access_cycles", 32'(acc_cnt), 32'(acc_tab[cur_idx]));
            check("dir_write_cycles", 32'(wr_cnt), 32'(wr_tab[cur_idx]));
        end
        prev_rv = rsp_valid;

        if (post_rst) begin
            check_zero();
            post_rst = 1'b0;
        end
    endtask

    task automatic drive_and_update();
        cyc_t r;
        bit   have;
        have = exp_q.size() > 0;
        if (have) r = exp_q[0];

        presetn = !(have && r.rst);
        if (have) begin
            pready = r.pready; pslverr = r.pslverr; prdata = r.prdata;
        end else begin
            pready = $urandom_range(0, 1) != 0; pslverr = $urandom_range(0, 1) != 0; prdata = $urandom;
        end

        if (!have && resp_pend) begin
            if (hold_left > 0) begin
                rsp_ready = 1'b0;
                hold_left--;
            end else begin
                rsp_ready = $urandom_range(0, 2) != 0;
            end
        end else begin
            rsp_ready = $urandom_range(0, 1) != 0;
        end

        cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = 4'($urandom); cmd_mask = $urandom; cmd_prot = 3'($urandom);
        if (!have && !resp_pend) begin
            cmd_valid = 1'b0;
            if (cmd_i < cmds.size() && $urandom_range(0, 3) != 0) begin
                cmd_valid = 1'b1;
                cmd_op = 2'(cmds[cmd_i].op); cmd_addr = cmds[cmd_i].addr;
                cmd_wdata = cmds[cmd_i].wdata; cmd_strb = cmds[cmd_i].strb;
                cmd_mask = cmds[cmd_i].mask; cmd_prot = cmds[cmd_i].prot;
            end
        end else begin
            cmd_valid = $urandom_range(0, 1) != 0;
        end

        // Advance the model across the coming clock edge.
        if (!presetn) begin
            exp_q.delete();
            resp_pend = 1'b0;
            post_rst  = 1'b1;
        end else if (have) begin
            void'(exp_q.pop_front());
        end else if (resp_pend) begin
            if (rsp_ready) resp_pend = 1'b0;
        end else if (cmd_valid) begin
            build(cmds[cmd_i]);
            cur_idx = cmd_i;
            hs_cyc  = cyc;
            acc_cnt = 0;
            wr_cnt  = 0;
            cmd_i++;
        end
    endtask

    initial begin
        cmd_t c;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_mask = '0; cmd_prot = '0; rsp_ready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        n_pass = 0; n_total = 0; cyc = 0; cmd_i = 0; cur_idx = -1; hs_cyc = 0;
        acc_cnt = 0; wr_cnt = 0; resp_pend = 1'b0; prev_rv = 1'b0; hold_left = 0;
        e_rdata = '0; e_slverr = 1'b0; e_to = 1'b0;

        add_cmd(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 3'd0, 0, 0, 32'h0, 0, 0, 32'h0, -1, 0);
        add_cmd(1, 32'h20, 32'h0, 4'h0, 32'h0, 3'd1, 3, 0, 32'h1234_5678, 0, 0, 32'h0, -1, 0);
        add_cmd(2, 32'h30, 32'h0000_00AA, 4'h0, 32'h0000_00FF, 3'd2, 0, 0, 32'hFFFF_0000, 0, 0, 32'h0, -1, 0);
        add_cmd(1, 32'h40, 32'h0, 4'h0, 32'h0, 3'd3, 99, 0, 32'h5555_5555, 0, 0, 32'h0, -1, 0);
        add_cmd(0, 32'h44, 32'h0102_0304, 4'h5, 32'h0, 3'd4, 1, 0, 32'h0, 0, 0, 32'h0, -1, 0);
        add_cmd(2, 32'h50, 32'h1111_1111, 4'h0, 32'hFFFF_FFFF, 3'd5, 1, 1, 32'h0BAD_0BAD, 0, 0, 32'h0, -1, 0);
        add_cmd(1, 32'h60, 32'h0, 4'h0, 32'h0, 3'd6, 5, 0, 32'h7777_7777, 0, 0, 32'h0, 1, 0);
        add_cmd(1, 32'h70, 32'h0, 4'h0, 32'h0, 3'd7, 0, 0, 32'hCAFE_F00D, 0, 0, 32'h0, -1, 5);
        for (int i = 0; i < NRAND; i++) begin
            c.op = int'($urandom_range(0, 3));
            c.addr = $urandom; c.wdata = $urandom; c.mask = $urandom;
            c.rd1 = $urandom; c.rd2 = $urandom;
            c.strb = 4'($urandom); c.prot = 3'($urandom);
            c.w1 = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
            c.w2 = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
            c.err1 = $urandom_range(0, 7) == 0;
            c.err2 = $urandom_range(0, 7) == 0;
            c.rst_at = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 1)) : -1;
            c.hold = int'($urandom_range(0, 2));
            cmds.push_back(c);
        end

        repeat (2) @(posedge pclk);
        post_rst = 1'b1;
        while ((cmd_i < cmds.size() || exp_q.size() > 0 || resp_pend) && cyc < LIMIT) begin
            @(negedge pclk);
            compare();
            drive_and_update();
            cyc++;
        end
        check("cycle_budget", 32'(cyc < LIMIT), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb4m_ctrl.md
Name: apb4m_ctrl

Overview:
Synthesisable, parametrised APB4 requester: the successor of our behavioural APB3 master.
- Accepts commands over a valid/ready interface, runs one APB4 transfer at a time and returns a response over a second valid/ready interface.
- Adds PSTRB/PPROT, configurable address/data width, a hardware read-modify-write operation and an access-phase timeout.
- Sits between a register-programming sequencer or CPU bridge and an APB slave fabric.

Parameters:
ADDR_W, 32, width of paddr/cmd_addr
DATA_W, 32, width of pwdata/prdata; must be 8, 16 or 32
TIMEOUT_CYC, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
presetn  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  operation: 0 WRITE, 1 READ, 2 RMW, 3 reserved (treated as READ)
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  byte strobes (WRITE); RMW bit mask is cmd_mask
cmd_mask  in  DATA_W  RMW bit-enable mask
cmd_prot  in  3  PPROT value
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (READ/RMW original value); 0 for WRITE
rsp_slverr  out  1  pslverr seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel, penable, pwrite  out  1 each  APB control
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB write strobes
pprot  out  3  APB protection
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
Reset and clocking:
- One clock, pclk. Reset presetn is synchronous and active-low.
- While presetn=0 at a pclk edge: state to IDLE and all outputs to 0, including cmd_ready and rsp_valid.
- Reset mid-transfer discards the command and produces no response.

FSM states:
- IDLE: cmd_ready=1 (only in IDLE, and only with presetn=1). On handshake, capture the command and go to SETUP.
- SETUP: psel=1, penable=0; paddr, pwrite, pprot, pwdata and pstrb are driven. Next cycle goes to ACCESS.
- ACCESS: psel=1, penable=1; APB signals stay stable.
  - pready=1 at an edge completes the transfer. pslverr and prdata are sampled at that edge.
- RESP: psel=0, penable=0, rsp_valid=1 with stable response fields. On rsp_ready, go to IDLE.

Latency:
- Zero-wait-state transfer: handshake at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid high in cycle N+3.
- Back-to-back commands are spaced by at least 4 cycles.

Read transfers (READ, and the read phase of RMW): pwrite=0, pstrb=0, pwdata=0.

RMW:
- Read phase first.
- On successful completion, go straight to SETUP with psel held at 1 and penable=0, pwrite=1, pstrb all ones, pwdata = (cmd_wdata & cmd_mask) | (rdata & ~cmd_mask).
- rsp_rdata returns the original read value.
- If the read phase ends with error or timeout, skip the write phase and go to RESP.

Timeout:
- Counter cleared on entry to ACCESS; it increments each ACCESS cycle with pready=0.
- If pready=0 on the TIMEOUT_CYC-th ACCESS cycle: abort, go to RESP with rsp_slverr=1 and rsp_timeout=1.
- pready=1 on that same edge wins: normal completion.
- rsp_slverr = pslverr | timeout.

Other rules:
- Response fields are registered and held stable while rsp_valid=1 and rsp_ready=0.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- apb4m_pkg: op_e enum {OP_WRITE, OP_READ, OP_RMW}, state_e enum {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP}, localparam-style functions for STRB_W = DATA_W/8 and the timeout counter width, $clog2(TIMEOUT_CYC+1).
- Sub-module apb4m_timeout: clear/enable counter with expiry flag, parametrised by TIMEOUT_CYC, tied off when TIMEOUT_CYC=0.

Test Plan:
1. WRITE addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, pready tied 1 -> psel rises 1 cycle after handshake, penable 1 cycle later, pwrite=1; rsp_valid 3 cycles after handshake with rsp_slverr=0 and rsp_rdata=0.
2. READ addr 0x20, slave holds pready=0 for 3 ACCESS cycles then returns prdata 0x1234_5678 -> APB signals stable throughout; rsp_rdata=0x1234_5678; pstrb=0 during the transfer.
3. RMW addr 0x30, slave reads 0xFFFF_0000, cmd_wdata 0x0000_00AA, cmd_mask 0x0000_00FF -> second access writes 0xFFFF_00AA with pstrb=0xF and psel high continuously; rsp_rdata=0xFFFF_0000.
4. TIMEOUT_CYC=4, slave never asserts pready -> exactly 4 ACCESS cycles, then psel=0, rsp_slverr=1, rsp_timeout=1; the next command is accepted normally.
5. RMW whose read returns pslverr=1 -> no write phase (pwrite never 1); rsp_slverr=1, rsp_timeout=0.
6. presetn=0 for 1 cycle during ACCESS, plus rsp_ready held 0 for 5 cycles in a separate run -> after reset all outputs are 0 and no response is produced; in the held case the response fields stay unchanged until the handshake.
